sigdelay: RTL and testbench

Sample-capture and delay block: the writer-side counterpart of the sine generator's counter-plus-ROM reader. Accepts a stream of sampled signal values (e.g. mic/ADC or a sinegen output), writes them into a circular dual-port RAM, and reads back the sample written `offset` samples earlier. A freeze mode stops writing and loop-replays the buffer contents. It sits between the sample source and the display/Vbuddy output path.

---
 rtl/sigdelay_pkg.sv | 14 +
 rtl/ram2port.sv | 41 ++++
 rtl/sigdelay.sv | 149 ++++++++++++++
 tb/tb_sigdelay.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sigdelay_pkg.sv
// rtl/sigdelay_pkg.sv - shared types for the sample delay/freeze block
//
// Purpose: state encoding for sigdelay.
//   state_t : IDLE=0, FILL=1, RUN=2, FREEZE=3 (2-bit, visible on state_o)
package sigdelay_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    RUN    = 2'd2,
    FREEZE = 2'd3
  } state_t;

endpackage

// File: rtl/ram2port.sv
// rtl/ram2port.sv - simple dual-port RAM, registered write-first read
//
// Purpose: one write port and one read port on a common clock.
// Ports:
//   clk, rst      : clock, async active-low reset (read register only)
//   we/waddr/wdata: write port
//   re/raddr      : read request; rdata updates one cycle after re
//   rdata         : registered read data, holds when re=0
module ram2port #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     re,
  input  logic [ADDRESS_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDRESS_WIDTH)-1];

  // Array kept out of the reset domain so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Write-first: a read hitting the address being written returns new data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/sigdelay.sv
// rtl/sigdelay.sv - circular-buffer sample delay with freeze/replay
//
// Purpose: writes accepted samples into a circular RAM and returns the one
// written offset samples earlier; FREEZE stops writing and loops the buffer.
// Ports:
//   clk, rst            : clock, async active-low reset
//   start, stop, freeze : control (stop > start > freeze)
//   sample_valid        : one-cycle strobe qualifying sample_in
//   sample_in           : input sample
//   offset              : delay in samples, latched on IDLE->FILL
//   dout, dout_valid    : delayed/replayed sample, one cycle after its strobe
//   state_o             : current state for debug
module sigdelay
  import sigdelay_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     freeze,
  input  logic                     sample_valid,
  input  logic [DATA_WIDTH-1:0]    sample_in,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     dout_valid,
  output logic [1:0]               state_o
);

  state_t state_q, state_d;

  logic [ADDRESS_WIDTH-1:0] wr_addr, rd_addr, fill_cnt, offs_q;
  logic [ADDRESS_WIDTH-1:0] wr_addr_inc, fill_inc, ram_raddr;
  logic                     accept, launch, ram_re;

  assign wr_addr_inc = wr_addr + 1'b1;
  assign fill_inc    = fill_cnt + 1'b1;
  assign state_o     = state_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // Zero delay needs no prefill, so skip straight to RUN.
          if (start) state_d = (offset == '0) ? RUN : FILL;
        end
        FILL: begin
          // offs_q can only be zero here after leaving FREEZE.
          if ((offs_q == '0) || (accept && (fill_inc == offs_q))) state_d = RUN;
        end
        RUN: begin
          if (freeze) state_d = FREEZE;
        end
        FREEZE: begin
          if (!freeze) state_d = FILL;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / control decode
  always_comb begin
    launch    = 1'b0;
    accept    = 1'b0;
    ram_re    = 1'b0;
    ram_raddr = wr_addr - offs_q;
    if (!stop) begin
      case (state_q)
        IDLE:   launch = start;
        FILL:   accept = sample_valid;
        RUN: begin
          accept = sample_valid;
          ram_re = sample_valid;
        end
        FREEZE: begin
          ram_re    = sample_valid;
          ram_raddr = rd_addr;
        end
        default: ;
      endcase
    end
  end

  // Address counters, fill counter, offset latch and valid strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_addr    <= '0;
      rd_addr    <= '0;
      fill_cnt   <= '0;
      offs_q     <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= ram_re;
      if (launch) begin
        wr_addr  <= '0;
        fill_cnt <= '0;
        offs_q   <= offset;
      end
      if (accept) begin
        wr_addr <= wr_addr_inc;
      end
      if (accept && (state_q == FILL)) begin
        fill_cnt <= fill_inc;
      end
      // The oldest sample sits at the next write slot, accounting for a
      // sample written in the same cycle.
      if ((state_q == RUN) && freeze && !stop) begin
        rd_addr <= accept ? wr_addr_inc : wr_addr;
      end
      if ((state_q == FREEZE) && ram_re) begin
        rd_addr <= rd_addr + 1'b1;
      end
      if ((state_q == FREEZE) && !freeze && !stop) begin
        fill_cnt <= '0;
      end
    end
  end

  ram2port #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (accept),
    .waddr(wr_addr),
    .wdata(sample_in),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(dout)
  );

endmodule

// File: tb/tb_sigdelay.sv
// tb/tb_sigdelay.sv - scoreboard bench for sigdelay
module tb_sigdelay;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       freeze = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] sample_in = '0;
  logic [3:0] offset = '0;
  logic [7:0] dout;
  logic       dout_valid;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  sigdelay #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .freeze      (freeze),
    .sample_valid(sample_valid),
    .sample_in   (sample_in),
    .offset      (offset),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every expected output is due on a specific cycle; anything else is spurious.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      check("dout_valid", 32'(dout_valid), 32'd1);
      check("dout", 32'(dout), 32'(sb[0].data));
      void'(sb.pop_front());
    end else if (dout_valid) begin
      check("dout_valid_spurious", 32'(dout_valid), 32'd0);
    end
  end

  task automatic drive(input logic sv, input logic [7:0] d, input logic st, input logic sp,
                       input bit expv, input logic [7:0] e);
    @(posedge clk); #1;
    sample_valid = sv;
    sample_in    = d;
    start        = st;
    stop         = sp;
    if (expv) sb.push_back('{cyc + 1, e});
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_start(input logic [3:0] off);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
    offset = off;
  endtask

  task automatic do_stop();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, then strobes while idle
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, 8'h00);
    idle();
    @(negedge clk);
    check("idle_state", 32'(state_o), 32'd0);
    check("idle_dout", 32'(dout), 32'd0);

    // Delay 3
    do_start(4'd3);
    for (int s = 10; s < 26; s++) drive(1'b1, 8'(s), 1'b0, 1'b0, s >= 13, 8'(s - 3));
    idle();
    @(negedge clk);
    check("d3_state_run", 32'(state_o), 32'd2);
    repeat (3) idle();
    @(negedge clk);
    check("d3_dout_hold", 32'(dout), 32'd22);
    do_stop();

    // Offset 0
    do_start(4'd0);
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55);
    drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 8'hAA);
    idle();
    do_stop();

    // Wrap with offset 15
    do_start(4'd15);
    for (int i = 0; i < 40; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, i >= 15, 8'(i - 15));
    idle();
    do_stop();

    // Freeze replay
    do_start(4'd0);
    for (int i = 0; i < 20; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b1, 8'(i));
    idle();
    freeze = 1'b1;
    idle();
    @(negedge clk);
    check("frz_state", 32'(state_o), 32'd3);
    for (int k = 0; k < 20; k++)
      drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 8'(k < 16 ? 4 + k : k - 12));
    idle();
    freeze = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("unfrz_state_fill", 32'(state_o), 32'd1);
    do_stop();

    // stop + start + sample_valid together in RUN
    do_start(4'd2);
    drive(1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 8'd1);
    drive(1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 8'h00);
    idle();
    @(negedge clk);
    check("prio_state_idle", 32'(state_o), 32'd0);
    check("prio_dout_hold", 32'(dout), 32'd1);

    // Reset mid-FILL
    do_start(4'd5);
    drive(1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 8'd8, 1'b0, 1'b0, 1'b0, 8'h00);
    idle();
    @(negedge clk);
    check("pre_rst_state_fill", 32'(state_o), 32'd1);
    #2; rst = 1'b0;
    #1;
    check("async_rst_state", 32'(state_o), 32'd0);
    check("async_rst_valid", 32'(dout_valid), 32'd0);
    check("async_rst_dout", 32'(dout), 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) idle();
    @(negedge clk);
    check("post_rst_state", 32'(state_o), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
